// File: rtl/branch_predictor.sv
// Bimodal branch predictor: direct-mapped 2-bit counter table plus a BTB, trained one cycle
// after execute resolves a branch. Define BP_GSHARE_EN to XOR global history into the counter index.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_f_i,
  output logic        predict_taken_o,
  output logic [31:0] predict_target_o,
  input  logic        execute_is_branch_i,
  input  logic        execute_branch_taken_i,
  input  logic [31:0] execute_pc_i,
  input  logic [31:0] execute_target_i,
  input  logic        branch_mispredict_i,
  output logic [31:0] branch_count_o,
  output logic [31:0] mispredict_count_o
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [1:0]          ctr_q    [ENTRIES];
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic        upd_is_branch;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;

  logic [INDEX_BITS-1:0] f_idx, f_cidx, u_idx, u_cidx;
  logic [TAG_BITS-1:0]   f_tag, u_tag;
  logic                  f_hit;

  assign f_idx = pc_f_i[INDEX_BITS+1:2];
  assign f_tag = pc_f_i[31:INDEX_BITS+2];
  assign u_idx = upd_pc[INDEX_BITS+1:2];
  assign u_tag = upd_pc[31:INDEX_BITS+2];

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q;

  // Lookup and update both hash with the committed history; the shift lands after the write.
  assign f_cidx = f_idx ^ INDEX_BITS'(ghr_q);
  assign u_cidx = u_idx ^ INDEX_BITS'(ghr_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (upd_is_branch) begin
      ghr_q <= {ghr_q[GHR_BITS-2:0], upd_taken};
    end
  end
`else
  assign f_cidx = f_idx;
  assign u_cidx = u_idx;
`endif

  // Table reads are plain register reads, so a same-cycle write is not visible until next cycle.
  assign f_hit            = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign predict_taken_o  = f_hit && ctr_q[f_cidx][1];
  assign predict_target_o = predict_taken_o ? target_q[f_idx] : pc_f_i + 32'd4;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_is_branch  <= 1'b0;
      upd_taken      <= 1'b0;
      upd_mispredict <= 1'b0;
      upd_pc         <= '0;
      upd_target     <= '0;
    end else begin
      upd_is_branch  <= execute_is_branch_i;
      upd_taken      <= execute_branch_taken_i;
      upd_mispredict <= branch_mispredict_i;
      upd_pc         <= execute_pc_i;
      upd_target     <= execute_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]   <= 2'b01;
        valid_q[i] <= 1'b0;
      end
    end else if (upd_is_branch) begin
      if (upd_taken) begin
        if (ctr_q[u_cidx] != 2'b11) ctr_q[u_cidx] <= ctr_q[u_cidx] + 2'd1;
        valid_q[u_idx] <= 1'b1;
      end else begin
        if (ctr_q[u_cidx] != 2'b00) ctr_q[u_cidx] <= ctr_q[u_cidx] - 2'd1;
      end
    end
  end

  // NOTE: tag/target storage has no reset; valid_q alone gates its use, keeping it plain RAM.
  always_ff @(posedge clk) begin
    if (rst_n && upd_is_branch && upd_taken) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_count_o     <= '0;
      mispredict_count_o <= '0;
    end else if (upd_is_branch) begin
      branch_count_o <= branch_count_o + 32'd1;
      if (upd_mispredict) mispredict_count_o <= mispredict_count_o + 32'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pc_f_i[1:0], upd_pc[1:0], (GHR_BITS > 0)};

endmodule
